// File: rtl/logic_shift_unit_if.sv
// Handshake bus of the logic/shift unit: operand/op request side and
// registered result side, each with its own valid/ready pair.
interface logic_shift_unit_if #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  A;
    logic [N-1:0]  B;
    logic [2:0]    op;
    logic [SW-1:0] shamt;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  R;
    logic          zero;
    logic          busy;

    // Producer/consumer side (drives operands, accepts results)
    modport master (
        output in_valid, A, B, op, shamt, out_ready,
        input  in_ready, out_valid, R, zero, busy
    );

    // Execution unit side
    modport slave (
        input  in_valid, A, B, op, shamt, out_ready,
        output in_ready, out_valid, R, zero, busy
    );
endinterface

// File: rtl/logic_shift_unit.sv
// Logical unit of the ALU cluster: AND/OR/XOR/NOR/LUI in one cycle,
// SLL/SRL/SRA iteratively at one bit per cycle. Result R and zero flag
// are registered and held until the consumer takes them.
module logic_shift_unit #(
    parameter int N  = 32,
    parameter int SW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset_n,
    logic_shift_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLL = 3'b100;
    localparam logic [2:0] OP_SRL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_LUI = 3'b111;

    state_t        state;
    state_t        state_nxt;
    logic          started;
    logic [N-1:0]  work;
    logic [SW-1:0] cnt;
    logic [2:0]    shop;
    logic          accept;
    logic          retire;
    logic          needs_shift;
    logic [N-1:0]  lres;
    logic [N-1:0]  shifted;

    // Single-cycle result; shift encodings land here only when shamt is 0
    function automatic logic [N-1:0] logic_result(input logic [N-1:0] a,
                                                  input logic [N-1:0] b,
                                                  input logic [2:0]   f);
        case (f)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_LUI:  return {b[N/2-1:0], {(N/2){1'b0}}};
            default: return a;
        endcase
    endfunction

    // One-bit step of the iterative shifter; SRA keeps the sign bit
    function automatic logic [N-1:0] shift_step(input logic [N-1:0] w,
                                                input logic [2:0]   f);
        logic signed [N-1:0] sw;
        sw = w;
        case (f)
            OP_SLL:  return {w[N-2:0], 1'b0};
            OP_SRL:  return {1'b0, w[N-1:1]};
            default: return $unsigned(sw >>> 1);
        endcase
    endfunction

    // Handshake decode and combinational result candidates
    always_comb begin
        accept      = bus.in_valid & bus.in_ready;
        retire      = bus.out_valid & bus.out_ready;
        needs_shift = (bus.op inside {OP_SLL, OP_SRL, OP_SRA}) && (bus.shamt != '0);
        lres        = logic_result(bus.A, bus.B, bus.op);
        shifted     = shift_step(work, shop);
    end

    // State register; started keeps in_ready low until the first edge out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            started <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = needs_shift ? SHIFT : DONE;
            SHIFT:   if (cnt == SW'(1)) state_nxt = DONE;
            DONE:    if (retire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        bus.in_ready  = started && (state == IDLE);
        bus.busy      = (state == SHIFT);
        bus.out_valid = (state == DONE);
    end

    // Operand capture, iterative shift and result/zero registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.R    <= '0;
            bus.zero <= 1'b0;
            work     <= '0;
            cnt      <= '0;
            shop     <= '0;
        end else if (accept) begin
            shop <= bus.op;
            if (needs_shift) begin
                work <= bus.A;
                cnt  <= bus.shamt;
            end else begin
                bus.R    <= lres;
                bus.zero <= (lres == '0);
            end
        end else if (state == SHIFT) begin
            work <= shifted;
            cnt  <= cnt - SW'(1);
            if (cnt == SW'(1)) begin
                bus.R    <= shifted;
                bus.zero <= (shifted == '0);
            end
        end
    end
endmodule

// File: tb/tb_logic_shift_unit.sv
// Bench for logic_shift_unit: scoreboard of expected results pushed at
// issue and popped when out_valid appears; one task per scenario.
module tb_logic_shift_unit;
    localparam int N = 32;

    logic clk;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;
    logic [N-1:0] sb[$];

    logic_shift_unit_if #(.N(N)) bus();

    logic_shift_unit #(.N(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] o, input int s);
        logic signed [N-1:0] sa;
        sa = a;
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return a << s;
            3'd5: return a >> s;
            3'd6: return $unsigned(sa >>> s);
            default: return {b[N/2-1:0], 16'h0000};
        endcase
    endfunction

    // Present one operation, wait (bounded) for acceptance, push expectation
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] o, input logic [4:0] s);
        int guard = 0;
        while (!bus.in_ready && guard < 200) begin tick(); guard++; end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL issue_in_ready got=%b exp=1", bus.in_ready); end
        bus.A = a; bus.B = b; bus.op = o; bus.shamt = s; bus.in_valid = 1'b1;
        sb.push_back(model(a, b, o, int'(s)));
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) tick();
        total++; if (bus.R !== 32'h0) begin bad++; $display("FAIL rst_R got=%h exp=0", bus.R); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL rst_zero got=%b exp=0", bus.zero); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        reset_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_pre got=%b exp=0", bus.in_ready); end
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_and();
        logic [N-1:0] exp;
        issue(32'hF0F0_00FF, 32'h0FF0_0F0F, 3'b000, 5'd0);
        exp = sb.pop_front();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL and_out_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.R !== exp || exp !== 32'h00F0_000F) begin bad++; $display("FAIL and_R got=%h exp=%h", bus.R, exp); end
        total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL and_zero got=%b exp=0", bus.zero); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL and_in_ready got=%b exp=0", bus.in_ready); end
        retire();
    endtask

    task automatic test_nor_hold();
        logic [N-1:0] exp;
        issue(32'hFFFF_0000, 32'h0000_FFFF, 3'b011, 5'd0);
        exp = sb.pop_front();
        total++; if (bus.R !== exp) begin bad++; $display("FAIL nor_R got=%h exp=%h", bus.R, exp); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL nor_zero got=%b exp=1", bus.zero); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.R !== exp) begin bad++; $display("FAIL nor_hold%0d out_valid=%b R=%h exp 1/%h", i, bus.out_valid, bus.R, exp); end
        end
        retire();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL nor_retire_ov got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL nor_retire_ir got=%b exp=1", bus.in_ready); end
        total++; if (bus.R !== 32'h0 || bus.zero !== 1'b1) begin bad++; $display("FAIL nor_keep R=%h zero=%b exp 0/1", bus.R, bus.zero); end
    endtask

    task automatic test_sra();
        logic [N-1:0] exp;
        int lat = 1;
        int nb  = 0;
        issue(32'h8000_0010, 32'h0, 3'b110, 5'd4);
        while (!bus.out_valid && lat < 100) begin if (bus.busy) nb++; tick(); lat++; end
        exp = sb.pop_front();
        total++; if (lat !== 5) begin bad++; $display("FAIL sra_latency got=%0d exp=5", lat); end
        total++; if (nb !== 4) begin bad++; $display("FAIL sra_busy_cycles got=%0d exp=4", nb); end
        total++; if (bus.R !== exp || exp !== 32'hF800_0001) begin bad++; $display("FAIL sra_R got=%h exp=%h", bus.R, exp); end
        retire();
    endtask

    task automatic test_shift_edges();
        logic [N-1:0] exp;
        int lat = 1;
        issue(32'h0000_0001, 32'h0, 3'b100, 5'd31);
        while (!bus.out_valid && lat < 100) begin
            if (lat == 10) begin bus.in_valid = 1'b1; bus.op = 3'b001; bus.A = 32'h5555_5555; end
            if (lat == 12) bus.in_valid = 1'b0;
            tick(); lat++;
        end
        bus.in_valid = 1'b0;
        exp = sb.pop_front();
        total++; if (lat !== 32) begin bad++; $display("FAIL sll31_latency got=%0d exp=32", lat); end
        total++; if (bus.R !== exp || exp !== 32'h8000_0000) begin bad++; $display("FAIL sll31_R got=%h exp=%h", bus.R, exp); end
        retire();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL sll31_after ov=%b ir=%b exp 0/1", bus.out_valid, bus.in_ready); end
        issue(32'h8000_0000, 32'h0, 3'b101, 5'd0);
        exp = sb.pop_front();
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL srl0_latency out_valid=%b exp=1", bus.out_valid); end
        total++; if (bus.R !== exp || exp !== 32'h8000_0000) begin bad++; $display("FAIL srl0_R got=%h exp=%h", bus.R, exp); end
        bus.in_valid = 1'b1; bus.op = 3'b010; bus.A = 32'h1234_5678;
        tick(); tick();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.R !== 32'h8000_0000) begin bad++; $display("FAIL srl0_ignored ov=%b R=%h exp 0/80000000", bus.out_valid, bus.R); end
    endtask

    task automatic test_lui_stability();
        logic [N-1:0] exp;
        issue(32'h0, 32'h1234_ABCD, 3'b111, 5'd0);
        exp = sb.pop_front();
        bus.B = 32'h0; bus.A = 32'hFFFF_FFFF; bus.op = 3'b000;
        tick(); tick();
        total++; if (bus.R !== exp || exp !== 32'hABCD_0000) begin bad++; $display("FAIL lui_R got=%h exp=%h", bus.R, exp); end
        total++; if (bus.zero !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("FAIL lui_flags zero=%b ov=%b exp 0/1", bus.zero, bus.out_valid); end
        retire();
    endtask

    task automatic test_reset_mid_shift();
        logic [N-1:0] exp;
        issue(32'h0000_0001, 32'h0, 3'b100, 5'd20);
        repeat (5) tick();
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
        reset_n = 1'b0;
        #1;
        sb.delete();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
        total++; if (bus.R !== 32'h0) begin bad++; $display("FAIL mid_R got=%h exp=0", bus.R); end
        tick();
        reset_n = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_release ov=%b ir=%b exp 0/1", bus.out_valid, bus.in_ready); end
        issue(32'hFFFF_FFFF, 32'h0F0F_0F0F, 3'b010, 5'd0);
        exp = sb.pop_front();
        total++; if (bus.out_valid !== 1'b1 || bus.R !== exp || exp !== 32'hF0F0_F0F0) begin bad++; $display("FAIL mid_xor ov=%b R=%h exp 1/%h", bus.out_valid, bus.R, exp); end
        retire();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] a, b, exp;
            logic [2:0]   o;
            logic [4:0]   s;
            int lat, explat;
            a = $urandom(); b = $urandom();
            if (i % 6 == 0) b = ~a;
            o = 3'($urandom_range(0, 7));
            s = 5'($urandom_range(0, 9));
            explat = (o inside {3'd4, 3'd5, 3'd6} && s != 0) ? int'(s) + 1 : 1;
            issue(a, b, o, s);
            lat = 1;
            while (!bus.out_valid && lat < 100) begin tick(); lat++; end
            exp = sb.pop_front();
            total++; if (bus.R !== exp) begin bad++; $display("FAIL b2b%0d_R op=%0d sh=%0d got=%h exp=%h", i, o, s, bus.R, exp); end
            total++; if (bus.zero !== (exp == 0)) begin bad++; $display("FAIL b2b%0d_zero got=%b exp=%b", i, bus.zero, exp == 0); end
            total++; if (lat !== explat) begin bad++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, lat, explat); end
            repeat ($urandom_range(0, 2)) tick();
            retire();
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_in_ready got=%b exp=1", i, bus.in_ready); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.op = '0; bus.shamt = '0;
        test_reset();
        test_and();
        test_nor_hold();
        test_sra();
        test_shift_edges();
        test_lui_stability();
        test_reset_mid_shift();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
